// File: rtl/count4_pwm_gen.sv
// count4_pwm_gen: PWM generator driven by an external 4-bit free-running
// counter used as a 16-cycle timebase. A duty value enters through a
// valid/ready handshake into a shadow slot and is applied only at a period
// boundary, so the output never changes duty mid-period. Also produces a
// period-start pulse and a sticky flag for count discontinuities.
//
// Handshake (duty_valid / duty_ready): a transfer happens on a clk edge where
// both are high. duty_ready is driven only from the pending-slot flag, so it
// never depends combinationally on duty_valid. A source holding duty_valid
// while duty_ready is low must keep duty_data stable until the transfer.
module count4_pwm_gen #(
    parameter int DUTY_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        count,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_data,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              pwm_out,
    output logic              period_start,
    output logic              seq_err
);

    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(16);

    logic [3:0]        r_prev_count;
    logic [DUTY_W-1:0] r_active_duty;
    logic [DUTY_W-1:0] r_pend_duty;
    logic              r_pend_valid;
    logic              r_pwm_out;
    logic              r_period_start;
    logic              r_seq_err;

    logic              w_wrap;
    logic              w_accept;
    logic              w_apply;
    logic              w_seq_ok;
    logic [DUTY_W-1:0] w_clamped;
    logic [DUTY_W-1:0] w_eff;
    logic              w_pwm_next;

    // Wrap, handshake, clamp, effective duty and next PWM level.
    always_comb begin
        w_wrap     = (count == 4'd0) && (r_prev_count == 4'hF);
        w_accept   = duty_valid && !r_pend_valid;
        w_apply    = w_wrap && r_pend_valid;
        w_seq_ok   = (count == (r_prev_count + 4'd1));
        w_clamped  = (duty_data > DUTY_MAX) ? DUTY_MAX : duty_data;
        // A duty applied on this wrap already governs the first cycle.
        w_eff      = w_apply ? r_pend_duty : r_active_duty;
        w_pwm_next = enable && ({1'b0, count} < w_eff);
    end

    // Previous-count tracker; reset to 15 so the first 0 counts as a wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_count <= 4'hF;
        end else begin
            r_prev_count <= count;
        end
    end

    // Shadow slot: accept into pend, hand over to active on a wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_duty   <= '0;
            r_pend_valid  <= 1'b0;
            r_active_duty <= '0;
        end else begin
            if (w_apply) begin
                r_active_duty <= r_pend_duty;
            end
            // Accept and apply are exclusive: accept needs an empty slot.
            if (w_accept) begin
                r_pend_duty  <= w_clamped;
                r_pend_valid <= 1'b1;
            end else if (w_apply) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Registered outputs: PWM level and period-start pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_out      <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_pwm_out      <= w_pwm_next;
            r_period_start <= w_wrap;
        end
    end

    // Sticky sequence error; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seq_err <= 1'b0;
        end else if (!w_seq_ok) begin
            r_seq_err <= 1'b1;
        end
    end

    assign duty_ready   = !r_pend_valid;
    assign pwm_out      = r_pwm_out;
    assign period_start = r_period_start;
    assign seq_err      = r_seq_err;

endmodule

// File: tb/tb_count4_pwm_gen.sv
// tb_count4_pwm_gen: directed bench for count4_pwm_gen. The bench drives the
// counter itself, one value per clock, and checks outputs 1 ns after each
// rising edge against hand-derived expectations.
module tb_count4_pwm_gen;

    logic       clk;
    logic       reset;
    logic [3:0] count;
    logic       enable;
    logic [4:0] duty_data;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_start;
    logic       seq_err;

    int n_cmp;
    int n_err;
    bit exp_seq;

    count4_pwm_gen #(.DUTY_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .count        (count),
        .enable       (enable),
        .duty_data    (duty_data),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .seq_err      (seq_err)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One counter cycle. exp_d is the duty expected to govern this sample,
    // en the enable level, ld a duty to offer for one edge (-1 = none).
    task automatic cyc(input int c, input int exp_d, input bit en, input int ld);
        enable = en;
        count  = 4'(c);
        if (ld >= 0) begin
            duty_valid = 1'b1;
            duty_data  = 5'(ld);
        end
        tick();
        if (ld >= 0) duty_valid = 1'b0;
        check($sformatf("pwm c=%0d d=%0d", c, exp_d), 32'(pwm_out), 32'(en && (c < exp_d)));
        check($sformatf("period_start c=%0d", c), 32'(period_start), 32'(c == 0));
        check($sformatf("seq_err c=%0d", c), 32'(seq_err), 32'(exp_seq));
    endtask

    task automatic period(input int exp_d, input int ld_c, input int ld_v);
        for (int c = 0; c < 16; c++) begin
            cyc(c, exp_d, 1'b1, (c == ld_c) ? ld_v : -1);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        exp_seq    = 1'b0;
        reset      = 1'b1;
        count      = 4'd0;
        enable     = 1'b1;
        duty_data  = 5'd0;
        duty_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset duty_ready", 32'(duty_ready), 32'd1);
        check("reset pwm_out", 32'(pwm_out), 32'd0);
        check("reset period_start", 32'(period_start), 32'd0);
        check("reset seq_err", 32'(seq_err), 32'd0);
        #2 reset = 1'b0;

        // 1: free-running count, nothing loaded.
        period(0, -1, 0);
        check("t1 duty_ready", 32'(duty_ready), 32'd1);
        period(0, -1, 0);

        // 2: duty 5 loaded at count 7.
        for (int c = 0; c < 7; c++) cyc(c, 0, 1'b1, -1);
        cyc(7, 0, 1'b1, 5);
        check("t2 ready low after accept", 32'(duty_ready), 32'd0);
        for (int c = 8; c < 16; c++) cyc(c, 0, 1'b1, -1);
        check("t2 ready low before wrap", 32'(duty_ready), 32'd0);
        cyc(0, 5, 1'b1, -1);
        check("t2 ready after wrap", 32'(duty_ready), 32'd1);
        for (int c = 1; c < 16; c++) cyc(c, 5, 1'b1, -1);
        period(5, -1, 0);

        // 3: pend 12 waiting, 3 held valid until ready rises.
        for (int c = 0; c < 3; c++) cyc(c, 5, 1'b1, -1);
        cyc(3, 5, 1'b1, 12);
        duty_valid = 1'b1;
        duty_data  = 5'd3;
        check("t3 ready low with pend", 32'(duty_ready), 32'd0);
        for (int c = 4; c < 16; c++) cyc(c, 5, 1'b1, -1);
        check("t3 held valid not taken", 32'(duty_ready), 32'd0);
        cyc(0, 12, 1'b1, -1);
        check("t3 ready after wrap", 32'(duty_ready), 32'd1);
        cyc(1, 12, 1'b1, -1);
        duty_valid = 1'b0;
        check("t3 held 3 accepted", 32'(duty_ready), 32'd0);
        for (int c = 2; c < 16; c++) cyc(c, 12, 1'b1, -1);

        // 4: duty 0, then 16, then 31 (clamped to 16).
        period(3, 5, 0);
        period(0, 5, 16);
        period(16, 5, 31);
        period(16, 5, 8);

        // 5: enable low for one full period with duty 8, duty 2 loaded inside.
        for (int c = 0; c < 8; c++) cyc(c, 8, 1'b1, -1);
        for (int c = 8; c < 16; c++) cyc(c, 8, 1'b0, (c == 10) ? 2 : -1);
        for (int c = 0; c < 8; c++) cyc(c, 2, 1'b0, -1);
        check("t5 ready after disabled wrap", 32'(duty_ready), 32'd1);
        for (int c = 8; c < 16; c++) cyc(c, 2, 1'b1, -1);
        period(2, -1, 0);

        // 6: count skips 6 -> 9, then async reset mid-period.
        for (int c = 0; c < 7; c++) cyc(c, 2, 1'b1, -1);
        exp_seq = 1'b1;
        for (int c = 9; c < 16; c++) cyc(c, 2, 1'b1, -1);
        cyc(0, 2, 1'b1, 7);
        cyc(1, 2, 1'b1, -1);
        check("t6 pend before reset", 32'(duty_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("t6 async seq_err", 32'(seq_err), 32'd0);
        check("t6 async pwm_out", 32'(pwm_out), 32'd0);
        check("t6 async duty_ready", 32'(duty_ready), 32'd1);
        check("t6 async period_start", 32'(period_start), 32'd0);
        exp_seq = 1'b0;
        count   = 4'd0;
        #2 reset = 1'b0;
        // Pending 7 was discarded and active returned to 0: all low.
        period(0, -1, 0);
        check("t6 ready after reset", 32'(duty_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/count4_pwm_gen.md
# count4_pwm_gen

Downstream consumer of the 4-bit free-running counter: takes its `count` bus as a 16-cycle timebase and drives a PWM output. The duty value is loaded through a valid/ready handshake into a shadow register and applied only at period boundaries, so the output never glitches mid-period. The block also flags a period-start pulse and latches a sticky error if the incoming count ever fails to step by exactly +1 mod 16.

## Interface

Parameters:

- `DUTY_W`, default 5: duty width. Fixed at 5 to cover 0..16. No other value is supported.

Ports:

- `clk` input 1: clock; the same clock as the counter.
- `reset` input 1: asynchronous, active-high reset; the same reset as the counter.
- `count` input 4: counter value, sampled every `clk` edge.
- `enable` input 1: PWM output enable.
- `duty_data` input 5: requested duty, in high-cycles per 16-cycle period.
- `duty_valid` input 1: `duty_data` is valid.
- `duty_ready` output 1: the shadow slot is empty and can accept a value.
- `pwm_out` output 1: registered PWM output.
- `period_start` output 1: one-cycle pulse, registered; marks the first PWM cycle of each period.
- `seq_err` output 1: sticky error flag for a count discontinuity.

## Operation

Registers and their reset values:
- `prev_count` = 4'hF
- `active_duty` = 0
- `pend_duty` = 0
- `pend_valid` = 0
- `pwm_out` = 0
- `period_start` = 0
- `seq_err` = 0
- `duty_ready` = 1, because it is combinational `!pend_valid`.

Wrap detect (combinational):
- `wrap` = (`count` == 0) && (`prev_count` == 15).
- `prev_count` <= `count` on every edge.
- Because `prev_count` resets to 4'hF, the first count of 0 after reset counts as a wrap.

Duty clamp:
- An accepted `duty_data` greater than 16 is stored as 16.
- Duty 0 means always low; duty 16 means always high.

Handshake:
- Accept happens when `duty_valid` && `duty_ready` at an edge; then `pend_duty` <= clamp(`duty_data`) and `pend_valid` <= 1.
- While `pend_valid` = 1, `duty_ready` = 0. A held `duty_valid` waits, and the source must keep `duty_data` stable.
- There is no bypass. A value accepted on a wrap edge goes to pend and applies at the next wrap.

Shadow update:
- On a wrap edge with `pend_valid` = 1 (the value held before that edge): `active_duty` <= `pend_duty` and `pend_valid` <= 0.
- `duty_ready` rises in the following cycle.

Effective duty:
- `eff` = (`wrap` && `pend_valid`) ? `pend_duty` : `active_duty`.
- The new duty therefore governs the period it starts, including its first cycle.

Output:
- `pwm_out` <= `enable` && ({1'b0,`count`} < `eff`), with the compare done at 5 bits.
- `period_start` <= `wrap`.

Enable:
- `enable` = 0 forces `pwm_out` to 0 from the next edge.
- The handshake, shadow update and error check keep running while `enable` is low.

Sequence check:
- If `count` != `prev_count` + 1 (mod 16) at an edge, then `seq_err` <= 1.
- `seq_err` is cleared only by `reset`.
- The PWM keeps operating on the raw `count` after an error.

Reset mid-operation:
- All registers return to their reset values asynchronously.
- Any pending duty is discarded, and `active_duty` becomes 0.

## Timing

- Output latency is 1 cycle: `pwm_out` and `period_start` after edge t reflect `count` sampled at edge t.
- With `active_duty` = D (0..16), each 16-cycle period has exactly D high cycles, starting with the cycle flagged by `period_start`.
- The earliest a duty takes effect is the period beginning at the first wrap strictly after the accept edge.
- Back-to-back accepts: at most one per period, because `duty_ready` stays low from accept until the cycle after the next wrap.
- `duty_ready` is combinational from a register only; there is no combinational path from `duty_valid` to `duty_ready`.

## Test plan

1. Reset, then drive `count` 0,1,…,15,0,… with no duty loaded.
   - `pwm_out` stays 0, `duty_ready` = 1, `seq_err` = 0.
   - `period_start` pulses the cycle after each count-0 sample, including the first one after reset.
2. Load duty 5 mid-period (count = 7), with `enable` = 1.
   - `duty_ready` drops the next cycle.
   - At the next wrap, `pwm_out` gives 5 high cycles then 11 low cycles, repeating.
   - `duty_ready` returns to 1 one cycle after the wrap.
3. Hold `duty_valid` with 3 while a pend of 12 is already waiting.
   - The 3 is not accepted until `duty_ready` rises.
   - The next period is 12 high; the period after that is 3 high.
4. Load duty 0, then 16, then 31, one per period.
   - 0 gives all-low, 16 gives all-high, and 31 is clamped so it behaves exactly as 16.
5. Deassert `enable` for one full period with duty 8, loading duty 2 during it.
   - `pwm_out` is 0 during the disabled period.
   - The update to 2 still happens at the wrap inside the disabled span.
6. Skip `count` from 6 to 9.
   - `seq_err` = 1 the cycle after the skip and stays 1.
   - An asynchronous `reset` asserted mid-period clears `seq_err`, `pwm_out`, `pend_valid` and `active_duty` immediately.
